// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception controller: exception codes,
// flag bit indices, Status/Cause field positions and FSM states.
package exc_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS     = 32'h0000_0008;
    localparam logic [31:0] EXC_BP      = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000A;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_TR      = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;
    localparam logic [31:0] EXC_ADEL_IF = 32'h0000_000F;

    localparam int NUM_FLAGS = 9;

    typedef enum logic [3:0] {
        FLG_ADEL_IF = 4'd0,
        FLG_RI      = 4'd1,
        FLG_SYS     = 4'd2,
        FLG_BRK     = 4'd3,
        FLG_TRAP    = 4'd4,
        FLG_OV      = 4'd5,
        FLG_ADEL_D  = 4'd6,
        FLG_ADES    = 4'd7,
        FLG_ERET    = 4'd8
    } flag_idx_e;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;
    localparam int ST_BEV   = 22;
    localparam int CA_IP_LO = 8;
    localparam int CA_IP_HI = 15;
    localparam int CA_SW_HI = 9;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selection of the winning exception source and its CP0 code.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [NUM_FLAGS-1:0] flags,
    input  logic                 int_pend,
    output logic [31:0]          code,
    output logic                 any_valid,
    output logic                 is_eret
);

    // Interrupts beat every synchronous fault; ERET only wins when nothing else is set.
    always_comb begin
        code      = EXC_NONE;
        any_valid = 1'b1;
        is_eret   = 1'b0;
        if (int_pend) begin
            code = EXC_INT;
        end else if (flags[FLG_ADEL_IF]) begin
            code = EXC_ADEL_IF;
        end else if (flags[FLG_RI]) begin
            code = EXC_RI;
        end else if (flags[FLG_SYS]) begin
            code = EXC_SYS;
        end else if (flags[FLG_BRK]) begin
            code = EXC_BP;
        end else if (flags[FLG_TRAP]) begin
            code = EXC_TR;
        end else if (flags[FLG_OV]) begin
            code = EXC_OV;
        end else if (flags[FLG_ADEL_D]) begin
            code = EXC_ADEL;
        end else if (flags[FLG_ADES]) begin
            code = EXC_ADES;
        end else if (flags[FLG_ERET]) begin
            code    = EXC_ERET;
            is_eret = 1'b1;
        end else begin
            any_valid = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller beside MEM: selects one event, reports it to
// CP0 in the same cycle, then holds the pipeline flush for FLUSH_CYCLES.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] VEC_BEV1     = 32'hBFC0_0380,
    parameter logic [31:0] VEC_BEV0     = 32'h8000_0180
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid_i,
    input  logic                 mem_stall_i,
    input  logic [31:0]          mem_pc_i,
    input  logic                 mem_in_delayslot_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [NUM_FLAGS-1:0] exc_flags_i,
    input  logic [31:0]          cp0_status_i,
    input  logic [31:0]          cp0_cause_i,
    input  logic [31:0]          cp0_epc_i,
    input  logic                 wb_cp0_we_i,
    input  logic [4:0]           wb_cp0_addr_i,
    input  logic [31:0]          wb_cp0_data_i,
    output logic [31:0]          except_type_o,
    output logic [31:0]          except_pc_o,
    output logic                 except_delayslot_o,
    output logic [31:0]          except_addr_o,
    output logic                 flush_o,
    output logic                 redirect_o,
    output logic [31:0]          redirect_pc_o
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_e      state_r;
    state_e      state_n;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_n;

    logic        status_hit_s;
    logic        cause_hit_s;
    logic        epc_hit_s;
    logic [31:0] status_s;
    logic [31:0] cause_s;
    logic [31:0] epc_s;
    logic        int_pend_s;
    logic [31:0] code_s;
    logic        any_valid_s;
    logic        is_eret_s;
    logic        commit_s;
    logic [31:0] vector_s;
    logic        unused_bits_s;

    assign status_hit_s = wb_cp0_we_i & (wb_cp0_addr_i == CP0_STATUS);
    assign cause_hit_s  = wb_cp0_we_i & (wb_cp0_addr_i == CP0_CAUSE);
    assign epc_hit_s    = wb_cp0_we_i & (wb_cp0_addr_i == CP0_EPC);

    // Forward an in-flight MTC0 so the decision sees the value CP0 is about to hold.
    always_comb begin
        status_s = cp0_status_i;
        cause_s  = cp0_cause_i;
        epc_s    = cp0_epc_i;
        if (status_hit_s) begin
            status_s[ST_IM_HI:ST_IM_LO] = wb_cp0_data_i[ST_IM_HI:ST_IM_LO];
            status_s[ST_EXL]            = wb_cp0_data_i[ST_EXL];
            status_s[ST_IE]             = wb_cp0_data_i[ST_IE];
        end else begin
            status_s = cp0_status_i;
        end
        if (cause_hit_s) begin
            cause_s[CA_SW_HI:CA_IP_LO] = wb_cp0_data_i[CA_SW_HI:CA_IP_LO];
        end else begin
            cause_s = cp0_cause_i;
        end
        if (epc_hit_s) begin
            epc_s = wb_cp0_data_i;
        end else begin
            epc_s = cp0_epc_i;
        end
    end

    assign int_pend_s = status_s[ST_IE] & ~status_s[ST_EXL]
                      & (|(cause_s[CA_IP_HI:CA_IP_LO] & status_s[ST_IM_HI:ST_IM_LO]));

    exc_prio_enc u_prio (
        .flags     (exc_flags_i),
        .int_pend  (int_pend_s),
        .code      (code_s),
        .any_valid (any_valid_s),
        .is_eret   (is_eret_s)
    );

    assign commit_s = (state_r == S_IDLE) & mem_valid_i & ~mem_stall_i & any_valid_s;
    assign vector_s = status_s[ST_BEV] ? VEC_BEV1 : VEC_BEV0;

    assign unused_bits_s = ^{status_s[31:23], status_s[21:16], status_s[7:2],
                             cause_s[31:16], cause_s[7:0]};

    // State and flush counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next state: the commit cycle already counts as the first flush cycle.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (commit_s) begin
                    cnt_n   = FLUSH_INIT;
                    state_n = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
                end else begin
                    cnt_n   = 4'd0;
                    state_n = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (cnt_r <= 4'd1) begin
                    cnt_n   = 4'd0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n   = cnt_r - 4'd1;
                    state_n = S_FLUSH;
                end
            end
            default: begin
                cnt_n   = 4'd0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs: zero-latency report on commit, flush-only while draining.
    always_comb begin
        except_type_o      = EXC_NONE;
        except_pc_o        = 32'h0000_0000;
        except_delayslot_o = 1'b0;
        except_addr_o      = 32'h0000_0000;
        flush_o            = 1'b0;
        redirect_o         = 1'b0;
        redirect_pc_o      = 32'h0000_0000;
        if (rst) begin
            flush_o = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (commit_s) begin
                        except_type_o      = code_s;
                        except_pc_o        = mem_pc_i;
                        except_delayslot_o = mem_in_delayslot_i;
                        except_addr_o      = mem_addr_i;
                        flush_o            = 1'b1;
                        redirect_o         = 1'b1;
                        redirect_pc_o      = is_eret_s ? epc_s : vector_s;
                    end else begin
                        flush_o = 1'b0;
                    end
                end
                S_FLUSH: begin
                    flush_o = 1'b1;
                end
                default: begin
                    flush_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Cycle-table bench for exc_ctrl: each row drives one cycle and its expected
// outputs go through a scoreboard queue checked before the next clock edge.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_stall_i, mem_in_delayslot_i;
    logic [31:0] mem_pc_i, mem_addr_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_addr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] except_type_o, except_pc_o, except_addr_o, redirect_pc_o;
    logic        except_delayslot_o, flush_o, redirect_o;

    typedef struct {
        logic        rst, valid, stall, ds, we;
        logic [31:0] pc, addr, status, cause, epc, wdata;
        logic [8:0]  flags;
        logic [4:0]  waddr;
    } stim_t;

    typedef struct {
        logic [31:0] typ, pc, addr, rpc;
        logic        ds, flush, redir;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam logic [31:0] ST_ON  = 32'h0000_FF01;
    localparam logic [31:0] ST_BEV = 32'h0040_FF01;
    localparam logic [31:0] V0     = 32'h8000_0180;
    localparam logic [31:0] V1     = 32'hBFC0_0380;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc_no   = 0;
    exp_t  sb_q[$];
    vec_t  tbl[$];

    exc_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_addr_i(mem_addr_i),
        .exc_flags_i(exc_flags_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_addr_i(wb_cp0_addr_i),
        .wb_cp0_data_i(wb_cp0_data_i), .except_type_o(except_type_o), .except_pc_o(except_pc_o),
        .except_delayslot_o(except_delayslot_o), .except_addr_o(except_addr_o),
        .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(input logic r, input logic v, input logic [8:0] f,
                                 input logic [31:0] pc, input logic [31:0] status,
                                 input logic [31:0] cause);
        stim_t s;
        s.rst = r; s.valid = v; s.stall = 1'b0; s.ds = 1'b0; s.we = 1'b0;
        s.pc = pc; s.addr = 32'h0; s.status = status; s.cause = cause;
        s.epc = 32'h0; s.wdata = 32'h0; s.flags = f; s.waddr = 5'd0;
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] typ, input logic [31:0] pc,
                                input logic ds, input logic [31:0] addr, input logic [31:0] rpc);
        exp_t e;
        e.typ = typ; e.pc = pc; e.ds = ds; e.addr = addr;
        e.flush = 1'b1; e.redir = 1'b1; e.rpc = rpc;
        return e;
    endfunction

    function automatic exp_t ex_none(input logic fl);
        exp_t e;
        e.typ = 32'h0; e.pc = 32'h0; e.ds = 1'b0; e.addr = 32'h0;
        e.flush = fl; e.redir = 1'b0; e.rpc = 32'h0;
        return e;
    endfunction

    function automatic stim_t idle();
        return st(1'b0, 1'b0, 9'h000, 32'h0, ST_ON, 32'h0);
    endfunction

    function automatic void add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %h expected %h", cyc_no, name, act, expv);
        end
    endtask

    // Drive one cycle, queue its expectation, check combinational outputs at negedge.
    task automatic run_cycle(input stim_t s, input exp_t e);
        exp_t x;
        rst = s.rst; mem_valid_i = s.valid; mem_stall_i = s.stall; mem_in_delayslot_i = s.ds;
        mem_pc_i = s.pc; mem_addr_i = s.addr; exc_flags_i = s.flags;
        cp0_status_i = s.status; cp0_cause_i = s.cause; cp0_epc_i = s.epc;
        wb_cp0_we_i = s.we; wb_cp0_addr_i = s.waddr; wb_cp0_data_i = s.wdata;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cycle %0d scoreboard: got empty queue expected entry", cyc_no);
        end else begin
            x = sb_q.pop_front();
            chk("except_type", except_type_o, x.typ);
            chk("except_pc", except_pc_o, x.pc);
            chk("except_delayslot", {31'h0, except_delayslot_o}, {31'h0, x.ds});
            chk("except_addr", except_addr_o, x.addr);
            chk("flush", {31'h0, flush_o}, {31'h0, x.flush});
            chk("redirect", {31'h0, redirect_o}, {31'h0, x.redir});
            chk("redirect_pc", redirect_pc_o, x.rpc);
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;

        add(st(1'b1, 1'b1, 9'h000, 32'h8000_1000, ST_ON, 32'h400), ex_none(1'b0));
        add(st(1'b1, 1'b1, 9'h004, 32'h8000_1000, ST_ON, 32'h400), ex_none(1'b0));
        add(idle(), ex_none(1'b0));
        add(st(1'b0, 1'b0, 9'h000, 32'h8000_1000, ST_ON, 32'h400), ex_none(1'b0));
        add(st(1'b0, 1'b1, 9'h000, 32'h8000_1000, ST_ON, 32'h400),
            ex(32'h1, 32'h8000_1000, 1'b0, 32'h0, V0));
        add(st(1'b0, 1'b1, 9'h000, 32'h8000_1000, ST_ON, 32'h400), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h000, 32'h8000_1000, 32'h0000_FF03, 32'h400), ex_none(1'b0));
        s = st(1'b0, 1'b1, 9'h022, 32'hBFC0_0100, ST_BEV, 32'h0);
        s.ds = 1'b1; s.addr = 32'h0000_1234;
        add(s, ex(32'hA, 32'hBFC0_0100, 1'b1, 32'h0000_1234, V1));
        add(idle(), ex_none(1'b1));
        s = st(1'b0, 1'b1, 9'h100, 32'h8000_2000, ST_ON, 32'h0);
        s.epc = 32'h1000; s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h2000;
        add(s, ex(32'hE, 32'h8000_2000, 1'b0, 32'h0, 32'h2000));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h004, 32'h8000_3000, ST_ON, 32'h400),
            ex(32'h1, 32'h8000_3000, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        s = st(1'b0, 1'b1, 9'h108, 32'h8000_4000, ST_ON, 32'h0);
        s.epc = 32'h1000;
        add(s, ex(32'h9, 32'h8000_4000, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        s = st(1'b0, 1'b1, 9'h000, 32'h8000_4800, ST_ON, 32'h400);
        s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0000_FF00;
        add(s, ex_none(1'b0));
        s = st(1'b0, 1'b1, 9'h000, 32'h8000_5000, ST_ON, 32'h0);
        s.we = 1'b1; s.waddr = 5'd13; s.wdata = 32'h0000_0100;
        add(s, ex(32'h1, 32'h8000_5000, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h010, 32'h8000_6000, ST_ON, 32'h0),
            ex(32'hD, 32'h8000_6000, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        s = st(1'b0, 1'b1, 9'h003, 32'h8000_7001, ST_ON, 32'h0);
        s.addr = 32'h8000_7001;
        add(s, ex(32'hF, 32'h8000_7001, 1'b0, 32'h8000_7001, V0));
        add(idle(), ex_none(1'b1));
        s = st(1'b0, 1'b1, 9'h080, 32'h8000_8000, ST_ON, 32'h0);
        s.addr = 32'h0000_0002;
        add(s, ex(32'h5, 32'h8000_8000, 1'b0, 32'h2, V0));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h00C, 32'h8000_8100, ST_ON, 32'h0),
            ex(32'h8, 32'h8000_8100, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h018, 32'h8000_8200, ST_ON, 32'h0),
            ex(32'h9, 32'h8000_8200, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h030, 32'h8000_8300, ST_ON, 32'h0),
            ex(32'hD, 32'h8000_8300, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h060, 32'h8000_8400, ST_ON, 32'h0),
            ex(32'hC, 32'h8000_8400, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        add(st(1'b0, 1'b1, 9'h0C0, 32'h8000_8500, ST_ON, 32'h0),
            ex(32'h4, 32'h8000_8500, 1'b0, 32'h0, V0));
        add(idle(), ex_none(1'b1));
        add(idle(), ex_none(1'b0));

        s = idle();
        s.rst = 1'b1;
        rst = 1'b1; mem_valid_i = 1'b0; mem_stall_i = 1'b0; mem_in_delayslot_i = 1'b0;
        mem_pc_i = 32'h0; mem_addr_i = 32'h0; exc_flags_i = 9'h0; cp0_status_i = 32'h0;
        cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; wb_cp0_we_i = 1'b0; wb_cp0_addr_i = 5'd0;
        wb_cp0_data_i = 32'h0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_cycle(tbl[i].s, tbl[i].e);

        // Stalled syscall is deferred, commits once unstalled; a repeat during flush is ignored.
        for (int k = 0; k < 3; k++) begin
            s = st(1'b0, 1'b1, 9'h004, 32'h8000_9000, ST_ON, 32'h0);
            s.stall = 1'b1;
            run_cycle(s, ex_none(1'b0));
        end
        run_cycle(st(1'b0, 1'b1, 9'h004, 32'h8000_9000, ST_ON, 32'h0),
                  ex(32'h8, 32'h8000_9000, 1'b0, 32'h0, V0));
        run_cycle(st(1'b0, 1'b1, 9'h004, 32'h8000_9004, ST_ON, 32'h0), ex_none(1'b1));
        run_cycle(idle(), ex_none(1'b0));

        // Reset while flushing drops flush at once; the next fault is handled normally.
        run_cycle(st(1'b0, 1'b1, 9'h004, 32'h8000_A000, ST_ON, 32'h0),
                  ex(32'h8, 32'h8000_A000, 1'b0, 32'h0, V0));
        s = idle();
        s.rst = 1'b1;
        run_cycle(s, ex_none(1'b0));
        run_cycle(idle(), ex_none(1'b0));
        s = st(1'b0, 1'b1, 9'h040, 32'h8000_A100, ST_ON, 32'h0);
        s.addr = 32'h0000_0003;
        run_cycle(s, ex(32'h4, 32'h8000_A100, 1'b0, 32'h3, V0));
        run_cycle(idle(), ex_none(1'b1));
        run_cycle(idle(), ex_none(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
